// File: rtl/block_dequantiser_stream.sv
// block_dequantiser_stream
// Fully pipelined MPEG-2 inverse quantiser. Expands a valid/ready stream of
// run/level/EOB tokens into 64 coefficients per block (one per cycle), looks up
// scan order and weights through external one-cycle ROMs and writes the
// dequantised, saturated coefficients with raster addresses.
//
// Optional feature: define BLOCK_DEQUANT_MISMATCH_EN to enable MPEG-2 mismatch
// control (LSB of the position-63 output toggled when the block sum is even).
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   start_i / busy_o / done_o      block control and status
//   err_o                          sticky run-overflow / bad DC run flag
//   macroblock_intra_i .. alternate_scan_i   block parameters, sampled on start
//   coeff_*                        token stream (valid/ready)
//   scan_addr_o / scan_data_i      scan ROM port, data one cycle after address
//   weight_addr_o / weight_data_i  weight ROM port, data one cycle after address
//   out_valid_o / out_addr_o / out_data_o   coefficient write port
module block_dequantiser_stream #(
  parameter int unsigned LEVEL_WIDTH = 12,
  parameter int unsigned OUT_WIDTH   = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  input  logic                          macroblock_intra_i,
  input  logic [1:0]                    intra_dc_precision_i,
  input  logic                          quant_scale_type_i,
  input  logic [4:0]                    quant_scale_code_i,
  input  logic                          alternate_scan_i,
  input  logic                          coeff_valid_i,
  output logic                          coeff_ready_o,
  input  logic [5:0]                    coeff_run_i,
  input  logic signed [LEVEL_WIDTH-1:0] coeff_level_i,
  input  logic                          coeff_eob_i,
  output logic [6:0]                    scan_addr_o,
  input  logic [5:0]                    scan_data_i,
  output logic [6:0]                    weight_addr_o,
  input  logic [7:0]                    weight_data_i,
  output logic                          out_valid_o,
  output logic [5:0]                    out_addr_o,
  output logic signed [OUT_WIDTH-1:0]   out_data_o
);

  localparam int unsigned PW = LEVEL_WIDTH + 17;
  localparam logic signed [PW-1:0] SatMax = PW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SatMin = ~SatMax;

  typedef enum logic [1:0] {StIdle, StRun, StFill} state_e;

  state_e state_q, state_d;
  logic       intra_q, alt_q, first_q, err_q;
  logic [1:0] dcprec_q;
  logic [7:0] qs_q, qs_new;
  logic [5:0] pos_q;

  logic                          hold_v_q, hold_eob_q;
  logic [5:0]                    hold_run_q;
  logic signed [LEVEL_WIDTH-1:0] hold_lvl_q;

  logic                          v1_q, dc1_q, last1_q, v2_q, dc2_q, last2_q;
  logic signed [LEVEL_WIDTH-1:0] lvl1_q, lvl2_q;
  logic [5:0]                    raster2_q;
  logic                          out_valid_q, done_q;
  logic [5:0]                    out_addr_q;
  logic signed [OUT_WIDTH-1:0]   out_data_q, out_next;

  logic busy, start_ok, accept;
  logic issue, issue_dc, free, to_fill, set_err, run_dec;
  logic signed [LEVEL_WIDTH-1:0] issue_lvl;
  logic [6:0] run_sum;

  assign busy     = (state_q != StIdle) | v1_q | v2_q | out_valid_q;
  assign start_ok = start_i & ~busy;
  assign run_sum  = {1'b0, pos_q} + {1'b0, hold_run_q};

  // Quantiser scale from code, linear or non-linear table.
  always_comb begin
    qs_new = '0;
    if (!quant_scale_type_i)             qs_new = {2'b00, quant_scale_code_i, 1'b0};
    else if (quant_scale_code_i == 5'd0) qs_new = '0;
    else if (quant_scale_code_i <= 5'd8) qs_new = {3'b000, quant_scale_code_i};
    else if (quant_scale_code_i <= 5'd16) qs_new = ({3'b000, quant_scale_code_i} << 1) - 8'd8;
    else if (quant_scale_code_i <= 5'd24) qs_new = ({3'b000, quant_scale_code_i} << 2) - 8'd40;
    else                                  qs_new = ({3'b000, quant_scale_code_i} << 3) - 8'd136;
  end

  // Token expansion: decide what (if anything) is issued at pos_q this cycle.
  always_comb begin
    issue     = 1'b0;
    issue_lvl = '0;
    issue_dc  = 1'b0;
    free      = 1'b0;
    to_fill   = 1'b0;
    set_err   = 1'b0;
    run_dec   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (hold_v_q) begin
          issue = 1'b1;
          if (hold_eob_q) begin
            free    = 1'b1;
            to_fill = 1'b1;
          end else if (intra_q && first_q) begin
            // Intra DC: run is forced to zero, a nonzero run is only flagged.
            issue_lvl = hold_lvl_q;
            issue_dc  = 1'b1;
            free      = 1'b1;
            set_err   = (hold_run_q != 6'd0);
          end else if (run_sum > 7'd63) begin
            // Level would land past position 63: drop it and zero-fill.
            set_err = 1'b1;
            free    = 1'b1;
            to_fill = 1'b1;
          end else if (hold_run_q != 6'd0) begin
            run_dec = 1'b1;
          end else begin
            issue_lvl = hold_lvl_q;
            free      = 1'b1;
          end
        end
      end
      StFill:  issue = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StRun;
      StRun: begin
        if (issue && pos_q == 6'd63) state_d = StIdle;
        else if (to_fill)            state_d = StFill;
      end
      StFill:  if (pos_q == 6'd63) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Refill the holder in the same cycle its level leaves, unless the block ends.
  assign coeff_ready_o = (state_q == StRun) &&
                         (!hold_v_q || (free && !to_fill && pos_q != 6'd63));
  assign accept        = coeff_valid_i & coeff_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      intra_q    <= 1'b0;
      alt_q      <= 1'b0;
      dcprec_q   <= '0;
      qs_q       <= '0;
      pos_q      <= '0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
      hold_v_q   <= 1'b0;
      hold_eob_q <= 1'b0;
      hold_run_q <= '0;
      hold_lvl_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        intra_q  <= macroblock_intra_i;
        alt_q    <= alternate_scan_i;
        dcprec_q <= intra_dc_precision_i;
        qs_q     <= qs_new;
        pos_q    <= '0;
        first_q  <= 1'b1;
        err_q    <= 1'b0;
        hold_v_q <= 1'b0;
      end else begin
        if (issue)   pos_q   <= pos_q + 6'd1;
        if (free)    first_q <= 1'b0;
        if (set_err) err_q   <= 1'b1;
        if (accept) begin
          hold_v_q   <= 1'b1;
          hold_eob_q <= coeff_eob_i;
          hold_run_q <= coeff_run_i;
          hold_lvl_q <= coeff_level_i;
        end else if (free) begin
          hold_v_q <= 1'b0;
        end else if (run_dec) begin
          hold_run_q <= hold_run_q - 6'd1;
        end
      end
    end
  end

  // Arithmetic stage (S2): weighting, scaling, truncating divide, saturation.
  logic signed [PW-1:0] lvl_ext, k_val, w_ext, qs_ext, prod, quot, dc_val, f_val, sat_val;
  logic [1:0] dc_shift;

  always_comb begin
    lvl_ext  = {{17{lvl2_q[LEVEL_WIDTH-1]}}, lvl2_q};
    w_ext    = {{(PW - 8){1'b0}}, weight_data_i};
    qs_ext   = {{(PW - 8){1'b0}}, qs_q};
    k_val    = '0;
    if (!intra_q) begin
      if (lvl2_q < 0)      k_val = '1;
      else if (lvl2_q > 0) k_val = PW'(1);
    end
    prod     = ((lvl_ext <<< 1) + k_val) * w_ext * qs_ext;
    quot     = prod[PW-1] ? -((-prod) >>> 5) : (prod >>> 5);
    dc_shift = 2'd3 - dcprec_q;
    dc_val   = lvl_ext <<< dc_shift;
    f_val    = dc2_q ? dc_val : quot;
    if (f_val > SatMax)      sat_val = SatMax;
    else if (f_val < SatMin) sat_val = SatMin;
    else                     sat_val = f_val;
  end

`ifdef BLOCK_DEQUANT_MISMATCH_EN
  logic par_q, par_all;
  assign par_all  = par_q ^ sat_val[0];
  assign out_next = (last2_q && !par_all) ? {sat_val[OUT_WIDTH-1:1], ~sat_val[0]}
                                          : sat_val[OUT_WIDTH-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           par_q <= 1'b0;
    else if (start_ok) par_q <= 1'b0;
    else if (v2_q)     par_q <= par_all;
  end
`else
  assign out_next = sat_val[OUT_WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      dc1_q       <= 1'b0;
      last1_q     <= 1'b0;
      lvl1_q      <= '0;
      v2_q        <= 1'b0;
      dc2_q       <= 1'b0;
      last2_q     <= 1'b0;
      lvl2_q      <= '0;
      raster2_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      v1_q        <= issue;
      dc1_q       <= issue_dc;
      last1_q     <= issue && (pos_q == 6'd63);
      lvl1_q      <= issue_lvl;
      v2_q        <= v1_q;
      dc2_q       <= dc1_q;
      last2_q     <= last1_q;
      lvl2_q      <= lvl1_q;
      raster2_q   <= scan_data_i;
      out_valid_q <= v2_q;
      done_q      <= v2_q & last2_q;
      out_addr_q  <= v2_q ? raster2_q : '0;
      out_data_q  <= v2_q ? out_next : '0;
    end
  end

  assign scan_addr_o   = issue ? {alt_q, pos_q} : '0;
  assign weight_addr_o = v1_q ? {intra_q, scan_data_i} : '0;
  assign busy_o        = busy;
  assign err_o         = err_q;
  assign done_o        = done_q;
  assign out_valid_o   = out_valid_q;
  assign out_addr_o    = out_addr_q;
  assign out_data_o    = out_data_q;

endmodule

// File: tb/tb_block_dequantiser_stream.sv
module tb_block_dequantiser_stream;
  localparam int LW = 12;
  localparam int OW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_i = 1'b0, busy_o, done_o, err_o;
  logic          intra = 1'b0, qtype = 1'b0, alt = 1'b0;
  logic [1:0]    prec = '0;
  logic [4:0]    code = '0;
  logic          coeff_valid_i = 1'b0, coeff_ready_o, coeff_eob_i = 1'b0;
  logic [5:0]    coeff_run_i = '0;
  logic [LW-1:0] coeff_level_i = '0;
  logic [6:0]    scan_addr_o, weight_addr_o;
  logic [5:0]    scan_data_i = '0;
  logic [7:0]    weight_data_i = '0;
  logic          out_valid_o;
  logic [5:0]    out_addr_o;
  logic signed [OW-1:0] out_data_o;

  block_dequantiser_stream #(.LEVEL_WIDTH(LW), .OUT_WIDTH(OW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start_i              (start_i),
    .busy_o               (busy_o),
    .done_o               (done_o),
    .err_o                (err_o),
    .macroblock_intra_i   (intra),
    .intra_dc_precision_i (prec),
    .quant_scale_type_i   (qtype),
    .quant_scale_code_i   (code),
    .alternate_scan_i     (alt),
    .coeff_valid_i        (coeff_valid_i),
    .coeff_ready_o        (coeff_ready_o),
    .coeff_run_i          (coeff_run_i),
    .coeff_level_i        (coeff_level_i),
    .coeff_eob_i          (coeff_eob_i),
    .scan_addr_o          (scan_addr_o),
    .scan_data_i          (scan_data_i),
    .weight_addr_o        (weight_addr_o),
    .weight_data_i        (weight_data_i),
    .out_valid_o          (out_valid_o),
    .out_addr_o           (out_addr_o),
    .out_data_o           (out_data_o)
  );

  int zz[64] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
                 12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
                 35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                 58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
  int az[64] = '{0, 8, 16, 24, 1, 9, 2, 10, 17, 25, 32, 40, 48, 56, 57, 49,
                 41, 33, 26, 18, 3, 11, 4, 12, 19, 27, 34, 42, 50, 58, 35, 43,
                 51, 59, 20, 28, 5, 13, 6, 14, 21, 29, 36, 44, 52, 60, 37, 45,
                 53, 61, 22, 30, 7, 15, 23, 31, 38, 46, 54, 62, 39, 47, 55, 63};
  int srom[128];
  int wrom[128];

  always @(posedge clk) begin
    scan_data_i   <= 6'(srom[scan_addr_o]);
    weight_data_i <= 8'(wrom[weight_addr_o]);
  end

  typedef struct {int run; int level; bit eob;} tok_t;
  typedef struct {int addr; int data; bit last;} exp_t;
  tok_t toks[$];
  exp_t expq[$];

  int n_tests = 0, n_fail = 0;
  int out_cnt = 0, done_cnt = 0;
  int obs[64];
  bit prev_done = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int qs_of(input bit t, input int c);
    if (!t) return 2 * c;
    if (c == 0) return 0;
    if (c <= 8) return c;
    if (c <= 16) return 2 * c - 8;
    if (c <= 24) return 4 * c - 40;
    return 8 * c - 136;
  endfunction

  function automatic longint deq(input longint lvl, input int w, input int qs, input bit intr);
    longint k;
    k = intr ? 0 : (lvl > 0 ? 1 : (lvl < 0 ? -1 : 0));
    return ((2 * lvl + k) * w * qs) / 32;
  endfunction

  function automatic int sat(input longint v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return int'(v);
  endfunction

  // Reference: walk the token list, place levels by scan position, then map to raster.
  task automatic model_block(input bit i_intra, input int i_prec, input bit i_qt,
                             input int i_code, input bit i_alt, output bit eerr);
    int vals[64];
    int pos, qs, ras;
    bit first;
    longint sum;
    foreach (vals[i]) vals[i] = 0;
    pos = 0; first = 1'b1; eerr = 1'b0;
    qs = qs_of(i_qt, i_code);
    for (int i = 0; i < toks.size(); i++) begin
      if (pos > 63 || toks[i].eob) break;
      if (i_intra && first) begin
        if (toks[i].run != 0) eerr = 1'b1;
        vals[0] = sat(longint'(toks[i].level) * (8 >> i_prec));
        pos = 1;
      end else if (pos + toks[i].run > 63) begin
        eerr = 1'b1;
        break;
      end else begin
        pos += toks[i].run;
        ras = i_alt ? az[pos] : zz[pos];
        vals[pos] = sat(deq(toks[i].level, wrom[(i_intra ? 64 : 0) + ras], qs, i_intra));
        pos++;
      end
      first = 1'b0;
    end
`ifdef BLOCK_DEQUANT_MISMATCH_EN
    sum = 0;
    foreach (vals[i]) sum += vals[i];
    if ((sum & 1) == 0) vals[63] = vals[63] ^ 1;
`endif
    for (int p = 0; p < 64; p++) begin
      exp_t e;
      e.addr = i_alt ? az[p] : zz[p];
      e.data = vals[p];
      e.last = (p == 63);
      expq.push_back(e);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("busy_after_done", busy_o, 0);
      prev_done = done_o;
      if (out_valid_o) begin
        if (expq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: addr %0d data %0d, expected no output",
                   out_addr_o, out_data_o);
        end else begin
          e = expq.pop_front();
          check("out_addr", out_addr_o, e.addr);
          check("out_data", out_data_o, e.data);
          check("done_flag", done_o, e.last);
        end
        obs[out_addr_o] = out_data_o;
        out_cnt++;
      end else if (done_o) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_without_valid: got done 1, expected 0");
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic gen_tokens(input int n, input int maxrun);
    tok_t t;
    toks.delete();
    for (int i = 0; i < n; i++) begin
      t.run = $urandom_range(0, maxrun);
      t.level = $urandom_range(0, 1) ? (int'($urandom_range(0, 20)) - 10)
                                     : (int'($urandom_range(0, 4095)) - 2048);
      t.eob = 1'b0;
      toks.push_back(t);
    end
    t.run = 0; t.level = 0; t.eob = 1'b1;
    toks.push_back(t);
  endtask

  function automatic tok_t mk(input int r, input int l, input bit e);
    tok_t t;
    t.run = r; t.level = l; t.eob = e;
    return t;
  endfunction

  // vmode: 0 gap-free, 1 valid every other cycle, 2 random valid.
  task automatic run_block(input bit i_intra, input int i_prec, input bit i_qt, input int i_code,
                           input bit i_alt, input int vmode, input int abort_at);
    bit eerr, fin, go;
    int idx, budget;
    model_block(i_intra, i_prec, i_qt, i_code, i_alt, eerr);
    out_cnt = 0; done_cnt = 0;
    foreach (obs[i]) obs[i] = 0;
    @(negedge clk); #2;
    intra = i_intra; prec = 2'(i_prec); qtype = i_qt; code = 5'(i_code); alt = i_alt;
    start_i = 1'b1;
    @(negedge clk); #2;
    start_i = 1'b0;
    idx = 0; budget = 0; fin = 1'b0;
    while (!fin) begin
      if (abort_at > 0 && out_cnt >= abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_out_addr", out_addr_o, 0);
        check("rst_done", done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", coeff_ready_o, 0);
        coeff_valid_i = 1'b0;
        expq.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (5) @(negedge clk);
        #2 check("no_out_after_reset", out_cnt, abort_at);
        return;
      end
      if (done_cnt > 0 && expq.size() == 0) begin
        fin = 1'b1;
      end else if (budget > 600) begin
        n_tests++;
        n_fail++;
        $display("FAIL block_timeout: %0d outputs left, expected 0", expq.size());
        expq.delete();
        fin = 1'b1;
      end else begin
        go = (idx < toks.size()) &&
             (vmode == 0 ? 1'b1 : (vmode == 1 ? (budget % 2 == 0) : ($urandom_range(0, 3) != 0)));
        coeff_valid_i = go;
        if (go) begin
          coeff_run_i   = 6'(toks[idx].run);
          coeff_level_i = LW'(toks[idx].level);
          coeff_eob_i   = toks[idx].eob;
          if (coeff_ready_o) idx++;
        end
        @(negedge clk); #2;
        budget++;
      end
    end
    coeff_valid_i = 1'b0;
    check("block_err", err_o, eerr);
    check("block_out_count", out_cnt, 64);
    check("block_done_count", done_cnt, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      srom[i] = zz[i];
      srom[64 + i] = az[i];
    end
    for (int i = 0; i < 128; i++) wrom[i] = 16;

    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid_o, 0);
    check("reset_out_data", out_data_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_err", err_o, 0);
    check("reset_ready", coeff_ready_o, 0);
    check("reset_scan_addr", scan_addr_o, 0);
    #2 rst = 1'b0;

    check("pin_deq", deq(-3, 16, 16, 1'b0), -56);
    check("pin_qs_nl31", qs_of(1'b1, 31), 112);
    check("pin_sat", sat(deq(-2048, 255, 112, 1'b0)), -2048);

    // Idle: tokens are not accepted.
    @(negedge clk); #2 coeff_valid_i = 1'b1;
    #1 check("idle_ready", coeff_ready_o, 0);
    coeff_valid_i = 1'b0;

    // Intra DC 10, precision 0.
    toks.delete();
    toks.push_back(mk(0, 10, 1'b0));
    toks.push_back(mk(0, 0, 1'b1));
    run_block(1'b1, 0, 1'b0, 8, 1'b0, 0, 0);
    check("dc_raster0", obs[0], 80);
`ifdef BLOCK_DEQUANT_MISMATCH_EN
    check("dc_raster63", obs[63], 1);
`else
    check("dc_raster63", obs[63], 0);
`endif

    // Non-intra, linear code 8, run 2 level -3.
    toks.delete();
    toks.push_back(mk(2, -3, 1'b0));
    toks.push_back(mk(0, 0, 1'b1));
    run_block(1'b0, 0, 1'b0, 8, 1'b0, 0, 0);
    check("ac_scan2", obs[8], -56);
    check("ac_raster1", obs[1], 0);

    // Saturation.
    for (int i = 0; i < 128; i++) wrom[i] = 255;
    toks.delete();
    toks.push_back(mk(0, 2047, 1'b0));
    toks.push_back(mk(0, -2048, 1'b0));
    toks.push_back(mk(0, 0, 1'b1));
    run_block(1'b0, 0, 1'b1, 31, 1'b0, 0, 0);
    check("sat_pos", obs[0], 2047);
    check("sat_neg", obs[1], -2048);

    // Bubbled input, both scans.
    for (int i = 0; i < 128; i++) wrom[i] = $urandom_range(1, 255);
    gen_tokens(20, 2);
    run_block(1'b0, 0, 1'b0, 5, 1'b0, 1, 0);
    gen_tokens(20, 2);
    run_block(1'b0, 0, 1'b1, 12, 1'b1, 1, 0);

    // Run overflow at pos 10.
    for (int i = 0; i < 128; i++) wrom[i] = 16;
    toks.delete();
    toks.push_back(mk(9, 5, 1'b0));
    toks.push_back(mk(60, 7, 1'b0));
    toks.push_back(mk(0, 0, 1'b1));
    run_block(1'b0, 0, 1'b0, 8, 1'b0, 0, 0);
    check("ovf_err", err_o, 1);
    check("ovf_scan9", obs[24], 88);

    // Reset after 20 outputs, then a clean block.
    gen_tokens(40, 1);
    run_block(1'b0, 0, 1'b0, 8, 1'b0, 0, 20);
    gen_tokens(20, 1);
    toks[0].run = 0;
    run_block(1'b1, 2, 1'b0, 3, 1'b0, 0, 0);
    check("clean_err", err_o, 0);

    // Randomised blocks.
    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < 128; i++) wrom[i] = $urandom_range(0, 255);
      gen_tokens($urandom_range(1, 25), ($urandom_range(0, 3) == 0) ? 40 : 4);
      run_block(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                $urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
